debug_mem_ctrl: RTL

- Downstream consumer of the Nios II debug-slave sysclk stage.
- Decodes the jdo word and the ocimem take_action / take_no_action strobes into reads and writes of a private 32-bit debug RAM.
- Returns read data on MonDReg, which feeds back upstream to the JTAG shift register.
- Also exposes an Avalon-MM slave so the CPU's debug monitor can access the same RAM. JTAG has arbitration priority over the CPU port.

---
 rtl/debug_mem_ctrl_if.sv | 33 +++
 rtl/debug_mem_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// debug_mem_ctrl_if
//   Avalon-MM bus bundle between the CPU debug monitor (master) and the debug
//   RAM controller (slave).
//   avs_address     word address into the debug RAM
//   avs_read        read request, held until avs_waitrequest drops
//   avs_write       write request, held until avs_waitrequest drops
//   avs_writedata   write data
//   avs_byteenable  per-byte write enables
//   avs_readdata    read data, valid in the cycle avs_waitrequest is low
//   avs_waitrequest stall back to the master
// ---------------------------------------------------------------------------
interface debug_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/debug_mem_ctrl.sv
// ---------------------------------------------------------------------------
// debug_mem_ctrl
//   Decodes JTAG ocimem strobes (from the debug-slave sysclk stage) into
//   reads/writes of a private 2^ADDR_W x 32 debug RAM, and shares that RAM with
//   an Avalon-MM slave port for the CPU debug monitor. JTAG has priority.
//
//   clk                      system clock
//   reset                    synchronous active-high reset
//   jdo[37:0]                command payload, valid only in a strobe cycle
//   take_action_ocimem_a     load MonAReg from jdo, optional read (no inc)
//   take_action_ocimem_b     write jdo data at MonAReg, then increment
//   take_no_action_ocimem_a  read at MonAReg, then increment
//   avs                      Avalon-MM slave (see debug_mem_ctrl_if)
//   MonDReg[31:0]            last JTAG read result
//   MonAReg[ADDR_W-1:0]      current JTAG word address
//   jtag_busy                a JTAG command is pending or in flight
// ---------------------------------------------------------------------------
module debug_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    debug_mem_ctrl_if.slave   avs,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_J_RD, S_C_RD} state_e;
    typedef enum logic [1:0] {CMD_RD, CMD_RD_INC, CMD_WR} cmd_e;

    // jdo field extraction (addr and wdata overlap; each command uses one)
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_rd_flag;
    logic [31:0]       jdo_wdata;
    logic              unused_jdo_bits;

    assign jdo_addr        = jdo[26 +: ADDR_W];
    assign jdo_rd_flag     = jdo[25];
    assign jdo_wdata       = jdo[34:3];
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    // state
    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    cmd_e              pend_type_q, pend_type_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              cpu_done_q, cpu_done_d;

    // RAM port
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    logic              jtag_active;
    logic              strobe_queues;
    logic              cpu_accept;

    assign jtag_active = pend_valid_q || (state_q == S_J_RD);

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_type_d   = pend_type_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        mon_d_d       = mon_d_q;
        mon_a_d       = mon_a_q;
        rdata_d       = rdata_q;
        cpu_done_d    = cpu_done_q;
        ram_we        = 1'b0;
        ram_be        = 4'h0;
        ram_addr      = pend_addr_q;
        ram_wdata     = pend_data_q;
        strobe_queues = 1'b0;
        cpu_accept    = 1'b0;

        // Strobe capture. Any strobe arriving while a command is pending or
        // in flight is ignored entirely, including an A-strobe address load,
        // so MonAReg never sees a load and an increment on the same edge.
        if (!jtag_active) begin
            if (take_action_ocimem_a) begin
                mon_a_d = jdo_addr;
                if (jdo_rd_flag) begin
                    strobe_queues = 1'b1;
                    pend_type_d   = CMD_RD;
                    pend_addr_d   = jdo_addr;
                end
            end else if (take_action_ocimem_b) begin
                strobe_queues = 1'b1;
                pend_type_d   = CMD_WR;
                pend_addr_d   = mon_a_q;
                pend_data_d   = jdo_wdata;
            end else if (take_no_action_ocimem_a) begin
                strobe_queues = 1'b1;
                pend_type_d   = CMD_RD_INC;
                pend_addr_d   = mon_a_q;
            end
        end
        if (strobe_queues) begin
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cpu_done_q) begin
                    // Completion cycle of a CPU read: data already registered.
                    // A JTAG command waits one cycle so the CPU sees the
                    // waitrequest drop it was promised.
                    cpu_done_d = 1'b0;
                    cpu_accept = 1'b1;
                end else if (pend_valid_q) begin
                    if (pend_type_q == CMD_WR) begin
                        ram_we       = 1'b1;
                        ram_be       = 4'hF;
                        pend_valid_d = 1'b0;
                        mon_a_d      = mon_a_q + ADDR_W'(1);
                    end else begin
                        state_d = S_J_RD;
                    end
                end else if (strobe_queues) begin
                    // A command queued this cycle already outranks the CPU.
                    cpu_accept = 1'b0;
                end else if (avs.avs_write) begin
                    ram_we     = 1'b1;
                    ram_be     = avs.avs_byteenable;
                    ram_addr   = avs.avs_address;
                    ram_wdata  = avs.avs_writedata;
                    cpu_accept = 1'b1;
                end else if (avs.avs_read) begin
                    ram_addr = avs.avs_address;
                    state_d  = S_C_RD;
                end
            end
            S_J_RD: begin
                mon_d_d      = ram_q;
                pend_valid_d = 1'b0;
                if (pend_type_q == CMD_RD_INC) begin
                    mon_a_d = mon_a_q + ADDR_W'(1);
                end
                state_d = S_IDLE;
            end
            S_C_RD: begin
                rdata_d    = ram_q;
                cpu_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_type_q  <= CMD_RD;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            mon_d_q      <= '0;
            mon_a_q      <= '0;
            rdata_q      <= '0;
            cpu_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            mon_d_q      <= mon_d_d;
            mon_a_q      <= mon_a_d;
            rdata_q      <= rdata_d;
            cpu_done_q   <= cpu_done_d;
        end
    end

    // One byte-wide RAM column per lane: byte enables map onto independent
    // write enables and each column infers a plain registered-read block RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] q_lane;

            always_ff @(posedge clk) begin
                if (ram_we && ram_be[gi]) begin
                    mem_lane[ram_addr] <= ram_wdata[gi*8 +: 8];
                end
                q_lane <= mem_lane[ram_addr];
            end

            assign ram_q[gi*8 +: 8] = q_lane;
        end
    endgenerate

    assign MonDReg             = mon_d_q;
    assign MonAReg             = mon_a_q;
    assign jtag_busy           = jtag_active;
    assign avs.avs_readdata    = rdata_q;
    assign avs.avs_waitrequest = reset || ((avs.avs_read || avs.avs_write) && !cpu_accept);

endmodule
